// File: rtl/mem_arbiter_if.sv
// Bundle of the instruction-cache, data-cache and RAM signals around mem_arbiter.
// slave = arbiter view; master = caches + RAM view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              iwait;
  logic [DATA_W-1:0] iload;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              dwait;
  logic [DATA_W-1:0] dload;
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  logic              ram_done;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_done,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_done,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one RAM port between the I-cache and D-cache; data side has priority.
// Define ARB_FAIR_EN to bound instruction starvation to MAX_DSTREAK data grants.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_DSTREAK = 4
) (
  input logic         CLK,
  input logic         nRST,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DGNT, IGNT, BUBBLE} state_t;

  state_t            state, next_state;
  logic              dreq;
  logic              fair_igrant;
  logic [ADDR_W-1:0] ram_a;
  logic [DATA_W-1:0] ram_s;

  if (MAX_DSTREAK < 1 || MAX_DSTREAK > 7) begin : g_cfg_check
    $error("mem_arbiter: MAX_DSTREAK must fit the 3-bit streak counter (1..7)");
  end

  assign dreq = bus.dREN | bus.dWEN;

`ifdef ARB_FAIR_EN
  logic [2:0] dstreak;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      dstreak <= '0;
    end else if (state == IGNT && bus.iREN && bus.ram_done) begin
      dstreak <= '0;
    end else if (state == IDLE && !bus.iREN) begin
      dstreak <= '0;
    end else if (state == DGNT && dreq && bus.ram_done && bus.iREN && dstreak != 3'd7) begin
      dstreak <= dstreak + 3'd1;
    end
  end

  assign fair_igrant = bus.iREN && (dstreak == 3'(MAX_DSTREAK));
`else
  assign fair_igrant = 1'b0;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  // RAM side is purely combinational from state and requester inputs, so an
  // async reset drops the strobes in the same cycle.
  always_comb begin
    next_state  = state;
    bus.ramREN  = 1'b0;
    bus.ramWEN  = 1'b0;
    ram_a       = '0;
    ram_s       = '0;
    bus.iload   = '0;
    bus.dload   = '0;
    bus.iwait   = 1'b1;
    bus.dwait   = 1'b1;

    unique case (state)
      IDLE: begin
        if (fair_igrant)    next_state = IGNT;
        else if (dreq)      next_state = DGNT;
        else if (bus.iREN)  next_state = IGNT;
      end

      DGNT: begin
        if (!dreq) begin
          next_state = IDLE;
        end else begin
          ram_a      = bus.daddr;
          ram_s      = bus.dstore;
          bus.ramWEN = bus.dWEN;
          bus.ramREN = bus.dREN & ~bus.dWEN;
          if (bus.ram_done) begin
            bus.dwait  = 1'b0;
            bus.dload  = bus.ramload;
            next_state = BUBBLE;
          end
        end
      end

      IGNT: begin
        if (!bus.iREN) begin
          next_state = IDLE;
        end else begin
          ram_a      = bus.iaddr;
          bus.ramREN = 1'b1;
          if (bus.ram_done) begin
            bus.iwait  = 1'b0;
            bus.iload  = bus.ramload;
            next_state = BUBBLE;
          end
        end
      end

      BUBBLE: next_state = IDLE;

      default: next_state = IDLE;
    endcase

    bus.ramaddr  = ram_a;
    bus.ramstore = ram_s;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single unified RAM port between the instruction-cache miss path and the data-cache path of the pipelined core.
- Sits between both caches and the memory controller/RAM model.
- Grants one requester at a time and holds the grant until the RAM completes the access.
- Steers address, data and strobes both ways; data side has priority, with optional starvation protection for the instruction side.

Parameters:
- ADDR_W, 32, width of word addresses on all address ports
- DATA_W, 32, width of the load/store data words
- MAX_DSTREAK, 4, consecutive data grants allowed while an instruction request waits (used only with ARB_FAIR_EN)

Ports:
- CLK  input  1  clock
- nRST  input  1  reset, asynchronous, active-low
- iREN  input  1  instruction-side read request
- iaddr  input  ADDR_W  instruction-side address
- iwait  output  1  instruction side stalled (low for exactly the completion cycle)
- iload  output  DATA_W  instruction read data, valid when iREN & ~iwait
- dREN  input  1  data-side read request
- dWEN  input  1  data-side write request
- daddr  input  ADDR_W  data-side address
- dstore  input  DATA_W  data-side write data
- dwait  output  1  data side stalled (low for exactly the completion cycle)
- dload  output  DATA_W  data read data, valid when dREN & ~dwait
- ramREN  output  1  RAM read strobe
- ramWEN  output  1  RAM write strobe
- ramaddr  output  ADDR_W  RAM address
- ramstore  output  DATA_W  RAM write data
- ramload  input  DATA_W  RAM read data
- ram_done  input  1  RAM completes the current access this cycle

Behaviour:
- State register: IDLE, DGNT, IGNT, BUBBLE. Reset (async, nRST=0) forces state IDLE.
- Defaults (every state unless overridden):
  - ramREN=ramWEN=0, ramaddr=0, ramstore=0
  - iload=dload=0
  - iwait=dwait=1
  - These are also the outputs during and immediately after reset.
- IDLE:
  - if dREN|dWEN -> DGNT
  - else if iREN -> IGNT
  - else stay
  - No RAM strobes in IDLE; a grant is issued one cycle after the request is seen.
- DGNT:
  - ramaddr=daddr; ramstore=dstore; ramWEN=dWEN; ramREN=dREN&~dWEN (write wins if both asserted).
  - On ram_done: dwait=0, dload=ramload, next BUBBLE.
  - If dREN|dWEN drops before ram_done: abort, strobes low that cycle, dwait stays 1, next IDLE.
- IGNT:
  - ramaddr=iaddr; ramREN=iREN.
  - On ram_done: iwait=0, iload=ramload, next BUBBLE.
  - If iREN drops before ram_done: abort to IDLE, iwait stays 1.
- BUBBLE:
  - One idle cycle, no strobes, next IDLE.
  - Guarantees the requester sees its wait low for exactly one cycle and can drop or change its request before re-arbitration.
- Requesters must hold address, data and strobes stable while their wait is high. Arbiter does not latch them; RAM signals are combinational from inputs plus state.
- Simultaneous dREN|dWEN and iREN in IDLE: data wins.
- ram_done arriving in IDLE or BUBBLE is ignored.
- Access latency: request seen in IDLE at cycle t; strobes driven from t+1; wait low in the ram_done cycle.
- Minimum 3 cycles per access including the bubble.
- Reset mid-grant: strobes drop immediately (async), state IDLE, no completion reported.

Optional Feature:
- Macro ARB_FAIR_EN.
- Defined:
  - 3-bit saturating counter dstreak, reset 0.
  - Increments on each completed DGNT while iREN is high; clears on any completed IGNT or when iREN is low in IDLE.
  - In IDLE, if dstreak==MAX_DSTREAK and iREN=1, go to IGNT even if data requests.
- Undefined: strict data priority; the instruction side may starve indefinitely.

Test Plan:
- Reset: hold nRST=0 with all requests high -> ramREN=ramWEN=0, iwait=dwait=1, loads 0.
- Instruction read alone: iREN=1, iaddr=0x0040, RAM returns 0xDEADBEEF with ram_done after 2 cycles -> ramREN=1, ramaddr=0x0040; iwait low one cycle with iload=0xDEADBEEF; BUBBLE follows.
- Data write: dWEN=1, daddr=0x0100, dstore=0x12345678 -> ramWEN=1, ramREN=0, ramstore=0x12345678; dwait low on ram_done; dREN&dWEN together -> write only.
- Contention: iREN and dREN asserted the same cycle -> data granted first; instruction granted after BUBBLE; iwait stays 1 throughout the data access.
- Abort and reset: drop iREN mid-IGNT -> IDLE, no iwait pulse; assert nRST=0 mid-DGNT -> ramWEN falls the same cycle, no dwait pulse.
- ARB_FAIR_EN with MAX_DSTREAK=4: iREN high, dREN held high continuously -> exactly 4 data completions, then one instruction grant, then data resumes; without the macro, no instruction grant occurs over 20 accesses.
